// File: rtl/s32x_fb_arb_pkg.sv
// Shared types and defaults for the 32X framebuffer arbiter.
package S32X_PKG;

    // Arbiter FSM: waiting for a grant, or running one memory access slot
    typedef enum logic {
        FB_IDLE,
        FB_ACCESS
    } FBARB_STATE_t;

    // Requester identities, listed in default priority order
    typedef enum logic [1:0] {
        REQ_DISP,
        REQ_FILL,
        REQ_WR,
        REQ_RD
    } FBARB_REQ_t;

    localparam int ACC_LEN_DEF   = 3;
    localparam int RD_STARVE_DEF = 4;

    // Byte-lane write strobes for a FIFO write. In the overwrite region a
    // zero byte is transparent and never written. Outside it, a zero byte
    // is still written when the other lane is also enabled, so a full-word
    // write keeps its zero half.
    function automatic logic [1:0] wr_lane_mask(input logic        ovr,
                                                input logic [15:0] d,
                                                input logic [1:0]  be);
        logic hi_nz;
        logic lo_nz;
        hi_nz = |d[15:8];
        lo_nz = |d[7:0];
        if (ovr) begin
            return {be[1] & hi_nz, be[0] & lo_nz};
        end
        return {be[1] & (hi_nz | be[0]), be[0] & (lo_nz | be[1])};
    endfunction

endpackage

// File: rtl/s32x_fb_arb.sv
// Framebuffer access arbiter: one bank, four requesters, fixed-length slots.
module s32x_fb_arb
    import S32X_PKG::*;
#(
    parameter int ACC_LEN   = ACC_LEN_DEF,
    parameter int RD_STARVE = RD_STARVE_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REFRESH,
    input  logic        DISP_REQ,
    input  logic [15:0] DISP_A,
    output logic        DISP_ACK,
    output logic [15:0] DISP_Q,
    input  logic        FILL_REQ,
    input  logic [15:0] FILL_A,
    input  logic [15:0] FILL_D,
    output logic        FILL_ACK,
    input  logic        WR_REQ,
    input  logic [17:1] WR_A,
    input  logic [15:0] WR_D,
    input  logic [1:0]  WR_BE,
    output logic        WR_ACK,
    input  logic        RD_REQ,
    input  logic [15:0] RD_A,
    output logic        RD_ACK,
    output logic [15:0] RD_Q,
    output logic [15:0] MEM_A,
    output logic [15:0] MEM_DO,
    output logic [1:0]  MEM_WE,
    output logic        MEM_RD,
    input  logic [15:0] MEM_DI,
    output logic        BUSY
);

    localparam logic [2:0] CNT_LOAD   = 3'(ACC_LEN - 1);
    localparam logic [2:0] STARVE_LIM = 3'(RD_STARVE);

    FBARB_STATE_t state;
    FBARB_STATE_t state_nxt;
    FBARB_REQ_t   cur_id;
    FBARB_REQ_t   grant_id;
    logic         grant;
    logic         starve_hit;
    logic [2:0]   count;
    logic [2:0]   starve_cnt;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision in IDLE and slot-end detection in ACCESS
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_id   = REQ_DISP;
        starve_hit = (starve_cnt == STARVE_LIM) && !REFRESH;
        if (state == FB_IDLE) begin
            if (DISP_REQ) begin
                grant    = 1'b1;
                grant_id = REQ_DISP;
            end else if (!REFRESH) begin
                if (RD_REQ && starve_hit) begin
                    grant    = 1'b1;
                    grant_id = REQ_RD;
                end else if (FILL_REQ) begin
                    grant    = 1'b1;
                    grant_id = REQ_FILL;
                end else if (WR_REQ) begin
                    grant    = 1'b1;
                    grant_id = REQ_WR;
                end else if (RD_REQ) begin
                    grant    = 1'b1;
                    grant_id = REQ_RD;
                end
            end
            if (grant) begin
                state_nxt = FB_ACCESS;
            end
        end else if (count == 3'd0) begin
            state_nxt = FB_IDLE;
        end
    end

    // Read starvation tracking: counts WR wins while a CPU read waits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_cnt <= 3'd0;
        end else if (!RD_REQ) begin
            starve_cnt <= 3'd0;
        end else if (grant && grant_id == REQ_RD) begin
            starve_cnt <= 3'd0;
        end else if (grant && grant_id == REQ_WR && starve_cnt != 3'd7) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Access slot datapath: latch the granted request, count the slot, finish with ACK
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_id   <= REQ_DISP;
            count    <= 3'd0;
            BUSY     <= 1'b0;
            MEM_A    <= 16'h0000;
            MEM_DO   <= 16'h0000;
            MEM_WE   <= 2'b00;
            MEM_RD   <= 1'b0;
            DISP_ACK <= 1'b0;
            FILL_ACK <= 1'b0;
            WR_ACK   <= 1'b0;
            RD_ACK   <= 1'b0;
            DISP_Q   <= 16'h0000;
            RD_Q     <= 16'h0000;
        end else begin
            DISP_ACK <= 1'b0;
            FILL_ACK <= 1'b0;
            WR_ACK   <= 1'b0;
            RD_ACK   <= 1'b0;
            if (grant) begin
                cur_id <= grant_id;
                count  <= CNT_LOAD;
                BUSY   <= 1'b1;
                case (grant_id)
                    REQ_DISP: begin
                        MEM_A  <= DISP_A;
                        MEM_WE <= 2'b00;
                        MEM_RD <= 1'b1;
                    end
                    REQ_FILL: begin
                        MEM_A  <= FILL_A;
                        MEM_DO <= FILL_D;
                        MEM_WE <= 2'b11;
                        MEM_RD <= 1'b0;
                    end
                    REQ_WR: begin
                        MEM_A  <= WR_A[16:1];
                        MEM_DO <= WR_D;
                        MEM_WE <= wr_lane_mask(WR_A[17], WR_D, WR_BE);
                        MEM_RD <= 1'b0;
                    end
                    default: begin
                        MEM_A  <= RD_A;
                        MEM_WE <= 2'b00;
                        MEM_RD <= 1'b1;
                    end
                endcase
            end else if (state == FB_ACCESS) begin
                if (count != 3'd0) begin
                    count <= count - 3'd1;
                end else begin
                    BUSY   <= 1'b0;
                    MEM_WE <= 2'b00;
                    MEM_RD <= 1'b0;
                    case (cur_id)
                        REQ_DISP: begin
                            DISP_ACK <= 1'b1;
                            DISP_Q   <= MEM_DI;
                        end
                        REQ_FILL: FILL_ACK <= 1'b1;
                        REQ_WR:   WR_ACK   <= 1'b1;
                        default: begin
                            RD_ACK <= 1'b1;
                            RD_Q   <= MEM_DI;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_s32x_fb_arb.sv
// Scoreboard bench for the framebuffer arbiter.
module tb_s32x_fb_arb;

    localparam int ACC_LEN   = 3;
    localparam int RD_STARVE = 4;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  we;
        logic        rd;
        logic [15:0] q;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REFRESH;
    logic        DISP_REQ;
    logic [15:0] DISP_A;
    logic        DISP_ACK;
    logic [15:0] DISP_Q;
    logic        FILL_REQ;
    logic [15:0] FILL_A;
    logic [15:0] FILL_D;
    logic        FILL_ACK;
    logic        WR_REQ;
    logic [17:1] WR_A;
    logic [15:0] WR_D;
    logic [1:0]  WR_BE;
    logic        WR_ACK;
    logic        RD_REQ;
    logic [15:0] RD_A;
    logic        RD_ACK;
    logic [15:0] RD_Q;
    logic [15:0] MEM_A;
    logic [15:0] MEM_DO;
    logic [1:0]  MEM_WE;
    logic        MEM_RD;
    logic [15:0] MEM_DI;
    logic        BUSY;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    logic busy_prev = 1'b0;
    logic cur_valid = 1'b0;
    logic auto_drop = 1'b1;
    exp_t cur;
    exp_t exp_q[$];
    int   grant_log[$];

    s32x_fb_arb #(.ACC_LEN(ACC_LEN), .RD_STARVE(RD_STARVE)) dut (
        .CLK(CLK), .RST_N(RST_N), .REFRESH(REFRESH),
        .DISP_REQ(DISP_REQ), .DISP_A(DISP_A), .DISP_ACK(DISP_ACK), .DISP_Q(DISP_Q),
        .FILL_REQ(FILL_REQ), .FILL_A(FILL_A), .FILL_D(FILL_D), .FILL_ACK(FILL_ACK),
        .WR_REQ(WR_REQ), .WR_A(WR_A), .WR_D(WR_D), .WR_BE(WR_BE), .WR_ACK(WR_ACK),
        .RD_REQ(RD_REQ), .RD_A(RD_A), .RD_ACK(RD_ACK), .RD_Q(RD_Q),
        .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
        .MEM_DI(MEM_DI), .BUSY(BUSY)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Framebuffer contents as seen by reads
    function automatic logic [15:0] rdata(input logic [15:0] a);
        return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    // Expected lane strobes for a FIFO write
    function automatic logic [1:0] exp_lanes(input logic ovr, input logic [15:0] d,
                                             input logic [1:0] be);
        logic [1:0] r;
        logic [7:0] b;
        for (int i = 0; i < 2; i++) begin
            b = d[8*i +: 8];
            r[i] = be[i] && ((b != 8'h00) || (!ovr && be[1-i]));
        end
        return r;
    endfunction

    function automatic exp_t mk(input int id, input logic [15:0] a, input logic [15:0] d,
                                input logic [1:0] we, input logic rd, input logic [15:0] q);
        exp_t e;
        e.id = id; e.a = a; e.d = d; e.we = we; e.rd = rd; e.q = q;
        return e;
    endfunction

    // One clock: scoreboard grants, held strobes, ACK timing, then requester drop on ACK
    task automatic tick();
        logic [3:0] ackv;
        logic [3:0] expv;
        @(posedge CLK);
        #1;
        cyc++;
        MEM_DI = rdata(MEM_A);
        ackv = {DISP_ACK, FILL_ACK, WR_ACK, RD_ACK};
        if (BUSY && !busy_prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_grant: got MEM_A=%h MEM_WE=%b MEM_RD=%b, wanted no grant",
                         MEM_A, MEM_WE, MEM_RD);
            end else begin
                cur = exp_q.pop_front();
                cur_valid = 1'b1;
                grant_cyc = cyc;
                grant_log.push_back(cyc);
                if ({MEM_A, MEM_WE, MEM_RD} !== {cur.a, cur.we, cur.rd}) begin
                    fails++;
                    $display("[TB] FAIL grant_id%0d: got A=%h WE=%b RD=%b, wanted A=%h WE=%b RD=%b",
                             cur.id, MEM_A, MEM_WE, MEM_RD, cur.a, cur.we, cur.rd);
                end
                if (cur.we != 2'b00) begin
                    tests++;
                    if (MEM_DO !== cur.d) begin
                        fails++;
                        $display("[TB] FAIL mem_do: got %h, wanted %h", MEM_DO, cur.d);
                    end
                end
            end
        end else if (BUSY && cur_valid) begin
            tests++;
            if ({MEM_A, MEM_WE, MEM_RD} !== {cur.a, cur.we, cur.rd}) begin
                fails++;
                $display("[TB] FAIL mem_hold: got A=%h WE=%b RD=%b, wanted A=%h WE=%b RD=%b",
                         MEM_A, MEM_WE, MEM_RD, cur.a, cur.we, cur.rd);
            end
        end else if (!BUSY) begin
            tests++;
            if (MEM_WE !== 2'b00 || MEM_RD !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_strobes: got WE=%b RD=%b, wanted 00/0", MEM_WE, MEM_RD);
            end
        end
        if (cur_valid && (cyc - grant_cyc) == ACC_LEN) begin
            expv = 4'b1000 >> cur.id;
            tests++;
            if (ackv !== expv) begin
                fails++;
                $display("[TB] FAIL ack_id%0d: got %b, wanted %b", cur.id, ackv, expv);
            end
            if (cur.id == 0) begin
                tests++;
                if (DISP_Q !== cur.q) begin
                    fails++;
                    $display("[TB] FAIL disp_q: got %h, wanted %h", DISP_Q, cur.q);
                end
            end else if (cur.id == 3) begin
                tests++;
                if (RD_Q !== cur.q) begin
                    fails++;
                    $display("[TB] FAIL rd_q: got %h, wanted %h", RD_Q, cur.q);
                end
            end
            cur_valid = 1'b0;
        end else if (ackv != 4'b0000) begin
            tests++;
            fails++;
            $display("[TB] FAIL stray_ack: got %b, wanted 0000", ackv);
        end
        if (auto_drop) begin
            if (DISP_ACK) DISP_REQ = 1'b0;
            if (FILL_ACK) FILL_REQ = 1'b0;
            if (WR_ACK)   WR_REQ   = 1'b0;
            if (RD_ACK)   RD_REQ   = 1'b0;
        end
        busy_prev = BUSY;
    endtask

    // Run until every expected access has completed, within a cycle budget
    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || cur_valid) && n < max_cyc) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || cur_valid) begin
            fails++;
            $display("[TB] FAIL timeout: got %0d accesses pending, wanted 0", exp_q.size() + int'(cur_valid));
            exp_q.delete();
            cur_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REFRESH = 1'b0;
        DISP_REQ = 1'b0; DISP_A = '0;
        FILL_REQ = 1'b0; FILL_A = '0; FILL_D = '0;
        WR_REQ = 1'b0; WR_A = '0; WR_D = '0; WR_BE = '0;
        RD_REQ = 1'b0; RD_A = '0; MEM_DI = '0;
        #3;
        tests++;
        if ({DISP_ACK, DISP_Q, FILL_ACK, WR_ACK, RD_ACK, RD_Q, MEM_A, MEM_DO, MEM_WE, MEM_RD, BUSY} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got nonzero (BUSY=%b MEM_A=%h RD_Q=%h), wanted all 0",
                     BUSY, MEM_A, RD_Q);
        end
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int c0;
        logic exp_rd;
        logic exp_ack;
        RD_A = 16'h0123;
        RD_REQ = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(3, 16'h0123, 16'h0000, 2'b00, 1'b1, 16'hBEEF));
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_rd  = (cyc - c0 >= 1) && (cyc - c0 <= 3);
            exp_ack = (cyc - c0 == 4);
            tests++;
            if (MEM_RD !== exp_rd || RD_ACK !== exp_ack) begin
                fails++;
                $display("[TB] FAIL read_timing c%0d: got RD=%b ACK=%b, wanted RD=%b ACK=%b",
                         cyc - c0, MEM_RD, RD_ACK, exp_rd, exp_ack);
            end
        end
        wait_idle(10);
        tests++;
        if (RD_Q !== 16'hBEEF) begin
            fails++;
            $display("[TB] FAIL read_data: got %h, wanted BEEF", RD_Q);
        end
    endtask

    task automatic test_priority();
        grant_log.delete();
        DISP_A = 16'h1000; FILL_A = 16'h2000; FILL_D = 16'h1357;
        WR_A = {1'b0, 16'h3000}; WR_D = 16'h1234; WR_BE = 2'b11;
        RD_A = 16'h4000;
        DISP_REQ = 1'b1; FILL_REQ = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
        exp_q.push_back(mk(0, 16'h1000, 16'h0000, 2'b00, 1'b1, rdata(16'h1000)));
        exp_q.push_back(mk(1, 16'h2000, 16'h1357, 2'b11, 1'b0, 16'h0000));
        exp_q.push_back(mk(2, 16'h3000, 16'h1234, 2'b11, 1'b0, 16'h0000));
        exp_q.push_back(mk(3, 16'h4000, 16'h0000, 2'b00, 1'b1, rdata(16'h4000)));
        wait_idle(40);
        for (int i = 1; i < grant_log.size(); i++) begin
            tests++;
            if (grant_log[i] - grant_log[i-1] != ACC_LEN + 1) begin
                fails++;
                $display("[TB] FAIL grant_spacing%0d: got %0d, wanted %0d",
                         i, grant_log[i] - grant_log[i-1], ACC_LEN + 1);
            end
        end
    endtask

    task automatic test_wr_lanes();
        logic [15:0] d;
        logic [1:0]  be;
        logic        ovr;
        logic [15:0] rq_keep;
        rq_keep = RD_Q;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                ovr = 1'b1; d = 16'h00FF; be = 2'b11;
            end else if (i == 1) begin
                ovr = 1'b0; d = 16'h00FF; be = 2'b11;
            end else if (i == 2) begin
                ovr = 1'b0; d = 16'h0000; be = 2'b01;
            end else begin
                ovr = 1'($urandom_range(0, 1));
                be  = 2'($urandom_range(0, 3));
                d[15:8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                d[7:0]  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            WR_A = {ovr, 16'h0500 + 16'(i)};
            WR_D = d;
            WR_BE = be;
            WR_REQ = 1'b1;
            exp_q.push_back(mk(2, 16'h0500 + 16'(i), d, exp_lanes(ovr, d, be), 1'b0, 16'h0000));
            wait_idle(12);
        end
        tests++;
        if (RD_Q !== rq_keep) begin
            fails++;
            $display("[TB] FAIL rd_q_hold: got %h, wanted %h", RD_Q, rq_keep);
        end
    endtask

    task automatic test_starvation();
        int n = 0;
        auto_drop = 1'b0;
        WR_A = {1'b0, 16'h0600}; WR_D = 16'h5555; WR_BE = 2'b11;
        RD_A = 16'h0700;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < RD_STARVE; w++) begin
                exp_q.push_back(mk(2, 16'h0600, 16'h5555, 2'b11, 1'b0, 16'h0000));
            end
            exp_q.push_back(mk(3, 16'h0700, 16'h0000, 2'b00, 1'b1, rdata(16'h0700)));
        end
        WR_REQ = 1'b1;
        RD_REQ = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;
        wait_idle(10);
        auto_drop = 1'b1;
    endtask

    task automatic test_refresh();
        int n = 0;
        WR_A = {1'b1, 16'h0040}; WR_D = 16'hAB00; WR_BE = 2'b11;
        WR_REQ = 1'b1;
        exp_q.push_back(mk(2, 16'h0040, 16'hAB00, 2'b10, 1'b0, 16'h0000));
        while (!cur_valid && n < 10) begin
            tick();
            n++;
        end
        REFRESH = 1'b1;
        FILL_A = 16'h0888; FILL_D = 16'h7E7E; FILL_REQ = 1'b1;
        RD_A = 16'h0999; RD_REQ = 1'b1;
        wait_idle(10);
        for (int k = 0; k < 6; k++) tick();
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("[TB] FAIL refresh_holdoff: got BUSY=%b, wanted 0", BUSY);
        end
        DISP_A = 16'h0777;
        DISP_REQ = 1'b1;
        exp_q.push_back(mk(0, 16'h0777, 16'h0000, 2'b00, 1'b1, rdata(16'h0777)));
        wait_idle(12);
        REFRESH = 1'b0;
        exp_q.push_back(mk(1, 16'h0888, 16'h7E7E, 2'b11, 1'b0, 16'h0000));
        exp_q.push_back(mk(3, 16'h0999, 16'h0000, 2'b00, 1'b1, rdata(16'h0999)));
        wait_idle(20);
    endtask

    task automatic test_reset_mid_access();
        int n = 0;
        FILL_A = 16'h0100; FILL_D = 16'hCAFE;
        FILL_REQ = 1'b1;
        exp_q.push_back(mk(1, 16'h0100, 16'hCAFE, 2'b11, 1'b0, 16'h0000));
        while (!cur_valid && n < 10) begin
            tick();
            n++;
        end
        tick();
        #1;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({DISP_ACK, DISP_Q, FILL_ACK, WR_ACK, RD_ACK, RD_Q, MEM_A, MEM_DO, MEM_WE, MEM_RD, BUSY} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got BUSY=%b MEM_WE=%b MEM_A=%h, wanted all 0",
                     BUSY, MEM_WE, MEM_A);
        end
        cur_valid = 1'b0;
        exp_q.push_back(mk(1, 16'h0100, 16'hCAFE, 2'b11, 1'b0, 16'h0000));
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (FILL_ACK !== 1'b0 || BUSY !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midreset_noack: got ACK=%b BUSY=%b, wanted 0/0", FILL_ACK, BUSY);
            end
        end
        RST_N = 1'b1;
        wait_idle(12);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_wr_lanes();
        test_starvation();
        test_refresh();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/s32x_fb_arb.md
S32X_FB_ARB -- requirements
Module: s32x_fb_arb

Interface
REQ-001 SHALL have parameter ACC_LEN, default 3, memory cycles per access slot (legal 2..7).
REQ-002 SHALL have parameter RD_STARVE, default 4, consecutive WR grants tolerated while RD is pending.
REQ-003 SHALL have the following ports, in this order:
- CLK  in  1  single clock.
- RST_N  in  1  reset, asynchronous, active-low.
- REFRESH  in  1  level; while high, no new FILL/WR/RD grants.
- DISP_REQ  in  1  display read request.
- DISP_A  in  16  display word address.
- DISP_ACK  out  1  display read done.
- DISP_Q  out  16  display read data.
- FILL_REQ  in  1  auto-fill write request.
- FILL_A  in  16  fill word address.
- FILL_D  in  16  fill data.
- FILL_ACK  out  1  fill write done.
- WR_REQ  in  1  FIFO write request.
- WR_A  in  17  [17:1]; bit 17 selects the overwrite region.
- WR_D  in  16  write data.
- WR_BE  in  2  byte enables {upper, lower}.
- WR_ACK  out  1  FIFO write done.
- RD_REQ  in  1  CPU read request.
- RD_A  in  16  CPU read address.
- RD_ACK  out  1  CPU read done.
- RD_Q  out  16  CPU read data.
- MEM_A  out  16  framebuffer address.
- MEM_DO  out  16  framebuffer write data.
- MEM_WE  out  2  framebuffer byte write strobes.
- MEM_RD  out  1  framebuffer read strobe.
- MEM_DI  in  16  framebuffer read data.
- BUSY  out  1  high while an access is in progress.

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> IDLE; grant decided only in IDLE.
REQ-005 Requests SHALL be level-held until the matching ACK; a request dropped before grant SHALL be treated as withdrawn.
REQ-006 Grant priority in IDLE SHALL be DISP > FILL > WR > RD, with FILL/WR/RD masked while REFRESH=1; DISP is never masked.
REQ-007 SHALL keep a 3-bit starvation count: +1 per WR grant while RD_REQ=1; cleared on any RD grant or when RD_REQ=0; when count equals RD_STARVE and REFRESH=0, RD outranks FILL and WR, but not DISP.
REQ-008 On grant, SHALL register requester ID, address, data and strobes, enter ACCESS, load a down-counter with ACC_LEN-1, and set BUSY.
REQ-009 During ACCESS, MEM_A/MEM_DO/MEM_WE/MEM_RD SHALL be held constant from registers; in IDLE, MEM_WE=0, MEM_RD=0, and MEM_A/MEM_DO hold their last values.
REQ-010 DISP and RD accesses SHALL drive MEM_RD=1 and MEM_WE=0; FILL accesses SHALL drive MEM_WE=2'b11.
REQ-011 WR accesses SHALL derive MEM_WE per lane as follows:
- WR_A[17]=1: lane enabled if its BE=1 and its data byte is nonzero.
- WR_A[17]=0: lane enabled if its BE=1 and (its data byte is nonzero or the other BE=1).
- A WR access with both lanes suppressed SHALL still occupy the slot and return WR_ACK.
REQ-012 On the clock edge ending the last ACCESS cycle (counter=0), SHALL: pulse the granted ACK for exactly 1 cycle, capture MEM_DI into DISP_Q or RD_Q for reads, clear BUSY, and return to IDLE.
REQ-013 Latency SHALL be: request sampled in IDLE at cycle N -> MEM strobes active in cycles N+1..N+ACC_LEN -> ACK high in cycle N+ACC_LEN+1.
REQ-014 Minimum spacing between consecutive grants SHALL be ACC_LEN+1 cycles (one IDLE cycle).
REQ-015 REFRESH or request deassertion during ACCESS SHALL NOT abort the current access.
REQ-016 DISP_Q and RD_Q SHALL hold their values until the next read by the same requester.

Reset
REQ-017 RST_N low SHALL asynchronously force:
- FSM to IDLE; counters to 0.
- All ACK outputs, BUSY, MEM_WE and MEM_RD to 0.
- MEM_A, MEM_DO, DISP_Q and RD_Q to 0.
REQ-018 Reset asserted mid-access SHALL discard the access with no ACK issued.

Structure
REQ-019 S32X_PKG SHALL hold the FSM state enum FBARB_STATE_t, the requester ID enum FBARB_REQ_t (DISP, FILL, WR, RD), and the default ACC_LEN/RD_STARVE constants.
REQ-020 SHALL be a single module with no sub-modules; one framebuffer bank per instance, with bank swapping external.

Verification
REQ-021 ACC_LEN=3; single RD_REQ at cycle 0, A=0x0123, MEM_DI=0xBEEF -> MEM_RD high in cycles 1-3, RD_ACK in cycle 4, RD_Q=0xBEEF.
REQ-022 DISP_REQ, FILL_REQ, WR_REQ and RD_REQ raised together -> grant order DISP, FILL, WR, RD, with grants spaced 4 cycles apart.
REQ-023 WR_A[17]=1, WR_D=0x00FF, WR_BE=11 -> MEM_WE=01; same data with WR_A[17]=0 -> MEM_WE=11; WR_D=0x0000, WR_BE=01, WR_A[17]=0 -> MEM_WE=00, WR_ACK still pulses.
REQ-024 WR_REQ and RD_REQ held continuously, RD_STARVE=4 -> RD granted after the 4th WR, and the pattern repeats.
REQ-025 REFRESH raised mid-WR access -> WR completes with ACK; FILL/WR/RD held off while REFRESH=1; DISP still granted.
REQ-026 RST_N pulsed low in the 2nd ACCESS cycle -> all outputs 0 immediately, no ACK; the pending request is re-granted after reset release.
